crosswalk_arbiter: RTL and testbench

Shares the intersection's single pedestrian walk phase among four crosswalk request buttons. It latches each button press as a pending request and tells the intersection controller when a walk phase is wanted. When the controller reports an all-red slot, the arbiter grants exactly one crosswalk, round-robin, times the walk interval in slow-clock ticks, and reports completion. It sits between the per-button debouncers and the traffic-light FSM, and replaces the single OR-ed walk flag.

---
 rtl/crosswalk_arbiter.sv | 147 ++++++++++++++
 tb/tb_crosswalk_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crosswalk_arbiter.sv
// Round-robin arbiter that shares one pedestrian walk phase among crosswalk buttons.
// Optional wait-timeout output `urgent` is built only when ARB_URGENT_EN is defined.
module crosswalk_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int WALK_TICKS = 3,
    parameter int MAX_WAIT   = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_tick,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_phase_ready,
    output logic               o_walk_pending,
    output logic [NUM_REQ-1:0] o_pending,
    output logic [NUM_REQ-1:0] o_grant,
    output logic               o_walk_on,
    output logic               o_walk_done,
    output logic               o_urgent
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARB,
        S_WALK,
        S_CLEAR
    } state_t;

    state_t             r_state;
    logic [NUM_REQ-1:0] r_req_q;
    logic [NUM_REQ-1:0] r_req_d;
    logic [NUM_REQ-1:0] r_pending;
    logic [PW-1:0]      r_rr_ptr;
    logic [PW-1:0]      r_gidx;
    logic [7:0]         r_tcnt;

    logic [NUM_REQ-1:0] w_rise;
    logic [NUM_REQ-1:0] w_clr;
    logic [PW-1:0]      w_sel;
    logic               w_found;
    logic [PW-1:0]      w_next_ptr;

    assign w_rise = r_req_q & ~r_req_d;
    assign w_clr  = (r_state == S_CLEAR) ?
                    ({{(NUM_REQ-1){1'b0}}, 1'b1} << r_gidx) : '0;

    assign o_pending      = r_pending;
    assign o_walk_pending = |r_pending;

    assign w_next_ptr = (r_gidx == PW'(NUM_REQ - 1)) ? '0 : r_gidx + 1'b1;

    // First pending index at or after rr_ptr, wrapping.
    always_comb begin
        int            v_sum;
        logic [PW-1:0] v_idx;
        w_sel   = '0;
        w_found = 1'b0;
        v_sum   = 0;
        v_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            v_sum = int'(r_rr_ptr) + i;
            if (v_sum >= NUM_REQ) v_sum = v_sum - NUM_REQ;
            v_idx = PW'(v_sum);
            if (!w_found && r_pending[v_idx]) begin
                w_found = 1'b1;
                w_sel   = v_idx;
            end
        end
    end

    // A set in the CLEAR cycle wins over the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req_q   <= '0;
            r_req_d   <= '0;
            r_pending <= '0;
        end else begin
            r_req_q   <= i_req;
            r_req_d   <= r_req_q;
            r_pending <= (r_pending & ~w_clr) | w_rise;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_gidx      <= '0;
            r_tcnt      <= '0;
            o_grant     <= '0;
            o_walk_on   <= 1'b0;
            o_walk_done <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (o_walk_pending && i_phase_ready) r_state <= S_ARB;
                end
                S_ARB: begin
                    r_gidx    <= w_sel;
                    r_tcnt    <= '0;
                    o_grant   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_sel;
                    o_walk_on <= 1'b1;
                    r_state   <= S_WALK;
                end
                S_WALK: begin
                    if (i_tick) begin
                        if (r_tcnt == 8'(WALK_TICKS - 1)) begin
                            o_grant     <= '0;
                            o_walk_on   <= 1'b0;
                            o_walk_done <= 1'b1;
                            r_state     <= S_CLEAR;
                        end else begin
                            r_tcnt <= r_tcnt + 8'd1;
                        end
                    end
                end
                S_CLEAR: begin
                    o_walk_done <= 1'b0;
                    r_rr_ptr    <= w_next_ptr;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef ARB_URGENT_EN
    logic [7:0] r_wait;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait <= '0;
        end else if (o_walk_done || !o_walk_pending) begin
            r_wait <= '0;
        end else if (r_state == S_IDLE && i_tick &&
                     r_wait != 8'(MAX_WAIT)) begin
            r_wait <= r_wait + 8'd1;
        end
    end

    assign o_urgent = (r_wait == 8'(MAX_WAIT));
`else
    assign o_urgent = 1'b0;
`endif

endmodule

// File: tb/tb_crosswalk_arbiter.sv
// Directed bench for crosswalk_arbiter: capture, round-robin, walk timing,
// set-beats-clear, async reset and the optional urgent timeout.
module tb_crosswalk_arbiter;

    logic       clk;
    logic       rst;
    logic       i_tick;
    logic [3:0] i_req;
    logic       i_phase_ready;
    logic       o_walk_pending;
    logic [3:0] o_pending;
    logic [3:0] o_grant;
    logic       o_walk_on;
    logic       o_walk_done;
    logic       o_urgent;

    int n_vec;
    int n_err;

`ifdef ARB_URGENT_EN
    localparam bit URG_EN = 1'b1;
`else
    localparam bit URG_EN = 1'b0;
`endif

    crosswalk_arbiter #(
        .NUM_REQ(4), .WALK_TICKS(3), .MAX_WAIT(15)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_tick(i_tick),
        .i_req(i_req),
        .i_phase_ready(i_phase_ready),
        .o_walk_pending(o_walk_pending),
        .o_pending(o_pending),
        .o_grant(o_grant),
        .o_walk_on(o_walk_on),
        .o_walk_done(o_walk_done),
        .o_urgent(o_urgent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_tick();
        i_tick = 1'b1;
        cyc(1);
        i_tick = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_tick = 1'b0;
        i_req = 4'b0000;
        i_phase_ready = 1'b0;
        cyc(2);
        #2 rst = 1'b0;
        cyc(1);
        n_vec++;
        if ({o_walk_pending, o_pending, o_grant, o_walk_on,
             o_walk_done, o_urgent} !== 12'h000) begin
            n_err++;
            $display("FAIL reset_outputs: got %h want 000",
                {o_walk_pending, o_pending, o_grant, o_walk_on,
                 o_walk_done, o_urgent});
        end
    endtask

    task automatic test_single_walk();
        i_req = 4'b0100;
        i_phase_ready = 1'b1;
        cyc(2);
        n_vec++;
        if (o_pending !== 4'b0100 || o_grant !== 4'b0000) begin
            n_err++;
            $display("FAIL single_capture: pend %b grant %b want 0100 0000",
                o_pending, o_grant);
        end
        cyc(2);
        n_vec++;
        if (o_grant !== 4'b0100 || o_walk_on !== 1'b1) begin
            n_err++;
            $display("FAIL single_grant: grant %b on %b want 0100 1",
                o_grant, o_walk_on);
        end
        do_tick();
        do_tick();
        n_vec++;
        if (o_walk_on !== 1'b1 || o_walk_done !== 1'b0) begin
            n_err++;
            $display("FAIL single_mid: on %b done %b want 1 0",
                o_walk_on, o_walk_done);
        end
        do_tick();
        n_vec++;
        if (o_walk_done !== 1'b1 || o_walk_on !== 1'b0 ||
            o_grant !== 4'b0000) begin
            n_err++;
            $display("FAIL single_done: done %b on %b grant %b want 1 0 0000",
                o_walk_done, o_walk_on, o_grant);
        end
        cyc(1);
        n_vec++;
        if (o_walk_done !== 1'b0 || o_pending !== 4'b0000) begin
            n_err++;
            $display("FAIL single_after: done %b pend %b want 0 0000",
                o_walk_done, o_pending);
        end
        i_req = 4'b0000;
        cyc(2);
    endtask

    task automatic test_round_robin();
        i_req = 4'b1001;
        cyc(2);
        n_vec++;
        if (o_pending !== 4'b1001) begin
            n_err++;
            $display("FAIL rr_capture: got %b want 1001", o_pending);
        end
        cyc(1);
        do_tick();
        n_vec++;
        if (o_grant !== 4'b1000) begin
            n_err++;
            $display("FAIL rr_first: got %b want 1000", o_grant);
        end
        do_tick();
        do_tick();
        n_vec++;
        if (o_walk_on !== 1'b1 || o_walk_done !== 1'b0) begin
            n_err++;
            $display("FAIL rr_arb_tick: on %b done %b want 1 0",
                o_walk_on, o_walk_done);
        end
        do_tick();
        n_vec++;
        if (o_walk_done !== 1'b1) begin
            n_err++;
            $display("FAIL rr_done1: got %b want 1", o_walk_done);
        end
        cyc(1);
        n_vec++;
        if (o_pending !== 4'b0001 || o_walk_done !== 1'b0) begin
            n_err++;
            $display("FAIL rr_left: pend %b done %b want 0001 0",
                o_pending, o_walk_done);
        end
        cyc(2);
        n_vec++;
        if (o_grant !== 4'b0001) begin
            n_err++;
            $display("FAIL rr_second: got %b want 0001", o_grant);
        end
        do_tick();
        do_tick();
        do_tick();
        n_vec++;
        if (o_walk_done !== 1'b1) begin
            n_err++;
            $display("FAIL rr_done2: got %b want 1", o_walk_done);
        end
        cyc(1);
        n_vec++;
        if (o_pending !== 4'b0000) begin
            n_err++;
            $display("FAIL rr_empty: got %b want 0000", o_pending);
        end
        i_req = 4'b0000;
        cyc(2);
    endtask

    task automatic test_held_req();
        i_req = 4'b0010;
        cyc(4);
        n_vec++;
        if (o_grant !== 4'b0010) begin
            n_err++;
            $display("FAIL held_grant: got %b want 0010", o_grant);
        end
        do_tick();
        do_tick();
        do_tick();
        cyc(1);
        n_vec++;
        if (o_pending !== 4'b0000) begin
            n_err++;
            $display("FAIL held_clear: got %b want 0000", o_pending);
        end
        cyc(5);
        n_vec++;
        if (o_pending !== 4'b0000 || o_grant !== 4'b0000) begin
            n_err++;
            $display("FAIL held_no_rereq: pend %b grant %b want 0000 0000",
                o_pending, o_grant);
        end
        i_req = 4'b0000;
        cyc(2);
    endtask

    task automatic test_set_on_clear();
        i_req = 4'b0010;
        cyc(4);
        n_vec++;
        if (o_grant !== 4'b0010) begin
            n_err++;
            $display("FAIL soc_grant: got %b want 0010", o_grant);
        end
        i_req = 4'b0000;
        do_tick();
        do_tick();
        i_req = 4'b0010;
        do_tick();
        n_vec++;
        if (o_walk_done !== 1'b1) begin
            n_err++;
            $display("FAIL soc_done: got %b want 1", o_walk_done);
        end
        cyc(1);
        n_vec++;
        if (o_pending !== 4'b0010) begin
            n_err++;
            $display("FAIL soc_kept: got %b want 0010", o_pending);
        end
        cyc(2);
        n_vec++;
        if (o_grant !== 4'b0010) begin
            n_err++;
            $display("FAIL soc_regrant: got %b want 0010", o_grant);
        end
        do_tick();
        do_tick();
        do_tick();
        cyc(1);
        i_req = 4'b0000;
        cyc(2);
    endtask

    task automatic test_reset_mid_walk();
        i_req = 4'b0001;
        cyc(4);
        n_vec++;
        if (o_grant !== 4'b0001) begin
            n_err++;
            $display("FAIL rstw_grant: got %b want 0001", o_grant);
        end
        do_tick();
        i_tick = 1'b1;
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if (o_walk_on !== 1'b0 || o_grant !== 4'b0000 ||
            o_pending !== 4'b0000 || o_walk_pending !== 1'b0) begin
            n_err++;
            $display("FAIL rstw_async: on %b grant %b pend %b wp %b want 0",
                o_walk_on, o_grant, o_pending, o_walk_pending);
        end
        i_tick = 1'b0;
        i_req = 4'b0000;
        #1 rst = 1'b0;
        cyc(4);
        n_vec++;
        if (o_grant !== 4'b0000 || o_walk_on !== 1'b0 ||
            o_walk_done !== 1'b0) begin
            n_err++;
            $display("FAIL rstw_idle: grant %b on %b done %b want 0",
                o_grant, o_walk_on, o_walk_done);
        end
    endtask

    task automatic test_urgent();
        i_phase_ready = 1'b0;
        i_req = 4'b0100;
        cyc(2);
        for (int i = 0; i < 14; i++) do_tick();
        n_vec++;
        if (o_urgent !== 1'b0) begin
            n_err++;
            $display("FAIL urg_tick14: got %b want 0", o_urgent);
        end
        do_tick();
        n_vec++;
        if (o_urgent !== URG_EN) begin
            n_err++;
            $display("FAIL urg_tick15: got %b want %b", o_urgent, URG_EN);
        end
        do_tick();
        do_tick();
        do_tick();
        n_vec++;
        if (o_urgent !== URG_EN) begin
            n_err++;
            $display("FAIL urg_hold: got %b want %b", o_urgent, URG_EN);
        end
        i_phase_ready = 1'b1;
        cyc(2);
        n_vec++;
        if (o_grant !== 4'b0100 || o_urgent !== URG_EN) begin
            n_err++;
            $display("FAIL urg_walk: grant %b urg %b want 0100 %b",
                o_grant, o_urgent, URG_EN);
        end
        do_tick();
        do_tick();
        do_tick();
        cyc(1);
        n_vec++;
        if (o_urgent !== 1'b0 || o_pending !== 4'b0000) begin
            n_err++;
            $display("FAIL urg_cleared: urg %b pend %b want 0 0000",
                o_urgent, o_pending);
        end
        i_req = 4'b0000;
        cyc(2);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_single_walk();
        test_round_robin();
        test_held_req();
        test_set_on_clear();
        test_reset_mid_walk();
        test_urgent();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
